// File: rtl/rx_vref_sweep_ctrl_pkg.sv
// Shared constants, FSM encoding and lane grading for the RX vref sweep.
// Defaults match the calibration FSMs that drive this block.
package rx_vref_sweep_ctrl_pkg;

  localparam int DEF_NUM_LANES      = 16;
  localparam int DEF_CODE_W         = 4;
  localparam int DEF_CODE_MIN       = 0;
  localparam int DEF_CODE_MAX       = 15;
  localparam int DEF_DEFAULT_CODE   = 8;
  localparam int DEF_SETTLE_CYCLES  = 8;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int MAX_LANES          = 64;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_APPLY = 3'd1,
    ST_TEST  = 3'd2,
    ST_EVAL  = 3'd3,
    ST_DONE  = 3'd4
  } sweep_state_e;

  // Zero-padded upper lanes are unmasked, so they never fail the reduction.
  function automatic logic lanes_pass(
    input logic [MAX_LANES-1:0] result,
    input logic [MAX_LANES-1:0] mask
  );
    return &(result | ~mask);
  endfunction

endpackage

// File: rtl/rx_vref_sweep_ctrl_if.sv
// Point-test channel between the vref sweep and the lane tester.
interface rx_vref_sweep_ctrl_if #(
  parameter int NUM_LANES = 16
);
  logic                 pt_start;
  logic                 pt_done;
  logic [NUM_LANES-1:0] pt_lanes_result;

  modport master (
    output pt_start,
    input  pt_done,
    input  pt_lanes_result
  );

  modport slave (
    input  pt_start,
    output pt_done,
    output pt_lanes_result
  );
endinterface

// File: rtl/rx_vref_window_tracker.sv
// Tracks the current passing run and the widest run seen so far.
// Ties keep the earlier (lower) window.
module rx_vref_window_tracker
  import rx_vref_sweep_ctrl_pkg::*;
#(
  parameter int CODE_W = DEF_CODE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              update,
  input  logic              pass,
  input  logic [CODE_W-1:0] code,
  output logic [CODE_W-1:0] best_lo,
  output logic [CODE_W-1:0] best_hi,
  output logic [CODE_W:0]   best_len,
  output logic [CODE_W-1:0] centre
);

  localparam logic [CODE_W:0]   LEN_ONE  = {{CODE_W{1'b0}}, 1'b1};
  localparam logic [CODE_W-1:0] CODE_ONE = {{(CODE_W-1){1'b0}}, 1'b1};

  logic [CODE_W-1:0] run_start_q, run_start_d;
  logic [CODE_W-1:0] best_start_q, best_start_d;
  logic [CODE_W:0]   run_len_q, run_len_d;
  logic [CODE_W:0]   best_len_q, best_len_d;
  logic [CODE_W-1:0] len_m1;

  always_comb begin
    run_start_d  = run_start_q;
    run_len_d    = run_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    if (clear) begin
      run_start_d  = '0;
      run_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else if (update) begin
      if (pass) begin
        if (run_len_q == '0) run_start_d = code;
        run_len_d = run_len_q + LEN_ONE;
      end else begin
        run_len_d = '0;
      end
      if (run_len_d > best_len_q) begin
        best_start_d = run_start_d;
        best_len_d   = run_len_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_start_q  <= '0;
      run_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      run_start_q  <= run_start_d;
      run_len_q    <= run_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  // len-1 fits CODE_W bits for any non-empty window, so modular math is exact.
  assign len_m1   = best_len_q[CODE_W-1:0] - CODE_ONE;
  assign best_lo  = best_start_q;
  assign best_hi  = best_start_q + len_m1;
  assign centre   = best_start_q + (len_m1 >> 1);
  assign best_len = best_len_q;

endmodule

// File: rtl/rx_vref_sweep_ctrl.sv
// RX vref sweep sequencer: steps codes, runs a point test per code,
// then programs the centre of the widest passing window.
module rx_vref_sweep_ctrl
  import rx_vref_sweep_ctrl_pkg::*;
#(
  parameter int NUM_LANES      = DEF_NUM_LANES,
  parameter int CODE_W         = DEF_CODE_W,
  parameter int CODE_MIN       = DEF_CODE_MIN,
  parameter int CODE_MAX       = DEF_CODE_MAX,
  parameter int DEFAULT_CODE   = DEF_DEFAULT_CODE,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_sweep_en,
  input  logic [NUM_LANES-1:0] i_lane_mask,
  rx_vref_sweep_ctrl_if.master pt,
  output logic [CODE_W-1:0]    o_vref_code,
  output logic                 o_sweep_done,
  output logic                 o_sweep_pass,
  output logic [CODE_W-1:0]    o_best_lo,
  output logic [CODE_W-1:0]    o_best_hi,
  output logic                 o_timeout_err
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SET_W-1:0]  SET_ONE     = SET_W'(1);
  localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_ONE      = TO_W'(1);
  localparam logic [CODE_W-1:0] C_MIN       = CODE_W'(CODE_MIN);
  localparam logic [CODE_W-1:0] C_MAX       = CODE_W'(CODE_MAX);
  localparam logic [CODE_W-1:0] C_DEF       = CODE_W'(DEFAULT_CODE);
  localparam logic [CODE_W-1:0] C_ONE       = CODE_W'(1);

  sweep_state_e         state_q, state_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic [SET_W-1:0]     settle_q, settle_d;
  logic [TO_W-1:0]      tmo_q, tmo_d;
  logic                 pass_q, pass_d;
  logic                 pt_start_q, pt_start_d;
  logic [CODE_W-1:0]    vref_q, vref_d;
  logic                 done_q, done_d;
  logic                 spass_q, spass_d;
  logic [CODE_W-1:0]    lo_q, lo_d;
  logic [CODE_W-1:0]    hi_q, hi_d;
  logic                 terr_q, terr_d;

  logic                 trk_clear;
  logic                 trk_update;
  logic [CODE_W-1:0]    trk_lo;
  logic [CODE_W-1:0]    trk_hi;
  logic [CODE_W:0]      trk_len;
  logic [CODE_W-1:0]    trk_centre;

  rx_vref_window_tracker #(
    .CODE_W (CODE_W)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .clear    (trk_clear),
    .update   (trk_update),
    .pass     (pass_q),
    .code     (code_q),
    .best_lo  (trk_lo),
    .best_hi  (trk_hi),
    .best_len (trk_len),
    .centre   (trk_centre)
  );

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    mask_d     = mask_q;
    settle_d   = '0;
    tmo_d      = '0;
    pass_d     = pass_q;
    pt_start_d = 1'b0;
    vref_d     = vref_q;
    done_d     = 1'b0;
    spass_d    = spass_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    terr_d     = terr_q;
    trk_clear  = 1'b0;
    trk_update = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_sweep_en) begin
          state_d   = ST_APPLY;
          code_d    = C_MIN;
          mask_d    = i_lane_mask;
          vref_d    = C_MIN;
          terr_d    = 1'b0;
          spass_d   = 1'b0;
          lo_d      = '0;
          hi_d      = '0;
          trk_clear = 1'b1;
        end
      end
      ST_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          state_d    = ST_TEST;
          pt_start_d = 1'b1;
        end else begin
          settle_d = settle_q + SET_ONE;
        end
      end
      ST_TEST: begin
        // A done coincident with our own start pulse belongs to no test.
        if (pt.pt_done && !pt_start_q) begin
          pass_d  = lanes_pass(MAX_LANES'(pt.pt_lanes_result),
                               MAX_LANES'(mask_q));
          state_d = ST_EVAL;
        end else if (tmo_q == TO_LAST) begin
          pass_d  = 1'b0;
          terr_d  = 1'b1;
          state_d = ST_EVAL;
        end else begin
          tmo_d = tmo_q + TO_ONE;
        end
      end
      ST_EVAL: begin
        trk_update = 1'b1;
        if (code_q == C_MAX) begin
          state_d = ST_DONE;
        end else begin
          code_d  = code_q + C_ONE;
          vref_d  = code_q + C_ONE;
          state_d = ST_APPLY;
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
        if (trk_len != '0) begin
          spass_d = 1'b1;
          vref_d  = trk_centre;
          lo_d    = trk_lo;
          hi_d    = trk_hi;
        end else begin
          spass_d = 1'b0;
          vref_d  = C_DEF;
          lo_d    = '0;
          hi_d    = '0;
        end
        if (!i_sweep_en) begin
          state_d = ST_IDLE;
          done_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!i_sweep_en && (state_q == ST_APPLY || state_q == ST_TEST ||
                        state_q == ST_EVAL)) begin
      state_d    = ST_IDLE;
      code_d     = code_q;
      pt_start_d = 1'b0;
      vref_d     = C_DEF;
      trk_update = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      code_q     <= C_MIN;
      mask_q     <= '0;
      settle_q   <= '0;
      tmo_q      <= '0;
      pass_q     <= 1'b0;
      pt_start_q <= 1'b0;
      vref_q     <= C_DEF;
      done_q     <= 1'b0;
      spass_q    <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      mask_q     <= mask_d;
      settle_q   <= settle_d;
      tmo_q      <= tmo_d;
      pass_q     <= pass_d;
      pt_start_q <= pt_start_d;
      vref_q     <= vref_d;
      done_q     <= done_d;
      spass_q    <= spass_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      terr_q     <= terr_d;
    end
  end

  assign pt.pt_start   = pt_start_q & i_sweep_en;
  assign o_vref_code   = vref_q;
  assign o_sweep_done  = done_q;
  assign o_sweep_pass  = spass_q;
  assign o_best_lo     = lo_q;
  assign o_best_hi     = hi_q;
  assign o_timeout_err = terr_q;

endmodule
